// File: rtl/pc_gen_pkg.sv
// Shared CPU constants for the fetch PC generator: next-PC select codes, reset and
// exception vectors, and the PC FSM state type.
package pc_gen_pkg;

  localparam logic [2:0] PcSelPc4    = 3'b000;
  localparam logic [2:0] PcSelJump   = 3'b001;
  localparam logic [2:0] PcSelEpc    = 3'b010;
  localparam logic [2:0] PcSelExcept = 3'b011;
  localparam logic [2:0] PcSelBranch = 3'b100;
  localparam logic [2:0] PcSelJr     = 3'b101;

  localparam logic [31:0] ResetPcDefault   = 32'hBFC0_0000;
  localparam logic [31:0] ExcVectorDefault = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHold
  } pc_state_e;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect-target select for pc_gen. Without PC_ALIGN_CHECK_EN the
// target is forced word-aligned.
module pc_target_mux
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = ExcVectorDefault
) (
  input  logic [2:0]  i_pcsel,
  input  logic [31:0] i_jump_addr,
  input  logic [31:0] i_branch_addr,
  input  logic [31:0] i_jr_addr,
  input  logic [31:0] i_epc,
  output logic        o_redirect,
  output logic [31:0] o_target
);

  logic [31:0] w_target_raw;

  always_comb begin
    o_redirect   = 1'b1;
    w_target_raw = 32'h0;
    case (i_pcsel)
      PcSelJump:   w_target_raw = i_jump_addr;
      PcSelEpc:    w_target_raw = i_epc;
      PcSelExcept: w_target_raw = EXC_VECTOR;
      PcSelBranch: w_target_raw = i_branch_addr;
      PcSelJr:     w_target_raw = i_jr_addr;
      // 000 and the unused codes 110/111 all mean sequential fetch
      default:     o_redirect   = 1'b0;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign o_target = w_target_raw;
`else
  assign o_target = {w_target_raw[31:2], 2'b00};
`endif

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HOLD FSM, one-entry redirect buffer and fetch
// handshake. PC_ALIGN_CHECK_EN enables misaligned-PC detection.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = ResetPcDefault,
  parameter logic [31:0] EXC_VECTOR = ExcVectorDefault
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  PCSel,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JRAddr,
  input  logic [31:0] EPC,
  input  logic        pc_stall,
  input  logic        if_ready,
  output logic        if_req,
  output logic [31:0] PC_IF,
  output logic        if_kill,
  output logic        addr_err
);

  pc_state_e   r_state;
  logic [31:0] r_pc;
  logic        r_pend;
  logic [31:0] r_pend_target;
  logic        r_req_out;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_fire;
  logic        w_align_hold;

  pc_target_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target_mux (
    .i_pcsel       (PCSel),
    .i_jump_addr   (JumpAddr),
    .i_branch_addr (BranchAddr),
    .i_jr_addr     (JRAddr),
    .i_epc         (EPC),
    .o_redirect    (w_redirect),
    .o_target      (w_target)
  );

`ifdef PC_ALIGN_CHECK_EN
  assign addr_err     = (r_pc[1:0] != 2'b00);
  assign w_align_hold = addr_err;
`else
  assign addr_err     = 1'b0;
  assign w_align_hold = 1'b0;
`endif

  // An unaccepted request stays asserted regardless of pc_stall until it fires.
  assign if_req  = (r_state != StBoot) && (r_req_out || !pc_stall) && !w_align_hold;
  assign w_fire  = if_req && if_ready;
  assign if_kill = w_fire && (r_pend || w_redirect);
  assign PC_IF   = r_pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= StBoot;
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_target <= 32'h0;
      r_req_out     <= 1'b0;
    end else begin
      r_req_out <= if_req && !if_ready;

      if (w_fire) begin
        if (w_redirect) begin
          r_pc <= w_target;
        end else if (r_pend) begin
          r_pc <= r_pend_target;
        end else begin
          r_pc <= r_pc + 32'd4;
        end
        r_pend <= 1'b0;
      end else if (w_align_hold && (w_redirect || r_pend)) begin
        // A misaligned PC never fires, so redirects load the PC directly.
        r_pc   <= w_redirect ? w_target : r_pend_target;
        r_pend <= 1'b0;
      end else if (w_redirect) begin
        r_pend        <= 1'b1;
        r_pend_target <= w_target;
      end

      case (r_state)
        StBoot:  r_state <= StRun;
        StRun:   if (w_redirect && !w_fire) r_state <= StHold;
        StHold:  if (w_fire) r_state <= StRun;
        default: r_state <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; expected values are hand-computed.
module tb_pc_gen;

  logic        clk;
  logic        resetn;
  logic [2:0]  PCSel;
  logic [31:0] JumpAddr;
  logic [31:0] BranchAddr;
  logic [31:0] JRAddr;
  logic [31:0] EPC;
  logic        pc_stall;
  logic        if_ready;
  logic        if_req;
  logic [31:0] PC_IF;
  logic        if_kill;
  logic        addr_err;

  int checks;
  int errors;

  pc_gen dut (
    .clk        (clk),
    .resetn     (resetn),
    .PCSel      (PCSel),
    .JumpAddr   (JumpAddr),
    .BranchAddr (BranchAddr),
    .JRAddr     (JRAddr),
    .EPC        (EPC),
    .pc_stall   (pc_stall),
    .if_ready   (if_ready),
    .if_req     (if_req),
    .PC_IF      (PC_IF),
    .if_kill    (if_kill),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; PCSel = 3'b000; JumpAddr = '0; BranchAddr = '0; JRAddr = '0; EPC = '0;
    pc_stall = 1'b0; if_ready = 1'b1;
    #12;
    checks++; if (PC_IF !== 32'hBFC0_0000) begin
      errors++; $display("FAIL reset_pc got %h want bfc00000", PC_IF); end
    checks++; if (if_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %b want 0", if_req); end
    checks++; if (if_kill !== 1'b0 || addr_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got kill=%b err=%b want 0 0", if_kill, addr_err); end
    resetn = 1'b1;
    #1;
    checks++; if (if_req !== 1'b0) begin
      errors++; $display("FAIL boot_req got %b want 0", if_req); end
    tick();
    checks++; if (if_req !== 1'b1 || PC_IF !== 32'hBFC0_0000) begin
      errors++; $display("FAIL run_first got req=%b pc=%h want 1 bfc00000", if_req, PC_IF); end
    tick();
    checks++; if (PC_IF !== 32'hBFC0_0004) begin
      errors++; $display("FAIL seq_pc1 got %h want bfc00004", PC_IF); end
    tick();
    checks++; if (PC_IF !== 32'hBFC0_0008) begin
      errors++; $display("FAIL seq_pc2 got %h want bfc00008", PC_IF); end
    tick();
    tick();
    checks++; if (PC_IF !== 32'hBFC0_0010) begin
      errors++; $display("FAIL seq_pc4 got %h want bfc00010", PC_IF); end
  endtask

  task automatic test_branch_hold();
    if_ready = 1'b0; PCSel = 3'b100; BranchAddr = 32'h8000_0100;
    #1;
    checks++; if (if_req !== 1'b1 || if_kill !== 1'b0) begin
      errors++; $display("FAIL hold_c1 got req=%b kill=%b want 1 0", if_req, if_kill); end
    tick();
    PCSel = 3'b000;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (PC_IF !== 32'hBFC0_0010 || if_req !== 1'b1) begin
        errors++; $display("FAIL hold_pc%0d got pc=%h req=%b want bfc00010 1", i, PC_IF, if_req);
      end
      tick();
    end
    if_ready = 1'b1;
    #1;
    checks++; if (if_kill !== 1'b1) begin
      errors++; $display("FAIL hold_kill got %b want 1", if_kill); end
    tick();
    checks++; if (PC_IF !== 32'h8000_0100 || if_kill !== 1'b0) begin
      errors++; $display("FAIL branch_pc got pc=%h kill=%b want 80000100 0", PC_IF, if_kill); end
  endtask

  task automatic test_latest_wins();
    if_ready = 1'b0; PCSel = 3'b100; BranchAddr = 32'h8000_0100;
    tick();
    PCSel = 3'b011;
    tick();
    PCSel = 3'b000; if_ready = 1'b1;
    #1;
    checks++; if (if_kill !== 1'b1 || PC_IF !== 32'h8000_0100) begin
      errors++; $display("FAIL lw_kill got kill=%b pc=%h want 1 80000100", if_kill, PC_IF); end
    tick();
    checks++; if (PC_IF !== 32'hBFC0_0380) begin
      errors++; $display("FAIL lw_pc got %h want bfc00380", PC_IF); end
  endtask

  task automatic test_stall();
    pc_stall = 1'b1; PCSel = 3'b101; JRAddr = 32'h8000_1000;
    #1;
    checks++; if (if_req !== 1'b0) begin
      errors++; $display("FAIL stall_req0 got %b want 0", if_req); end
    tick();
    PCSel = 3'b000;
    #1;
    checks++; if (if_req !== 1'b0 || PC_IF !== 32'hBFC0_0380) begin
      errors++; $display("FAIL stall_req1 got req=%b pc=%h want 0 bfc00380", if_req, PC_IF); end
    tick();
    pc_stall = 1'b0;
    #1;
    checks++; if (if_req !== 1'b1 || if_kill !== 1'b1) begin
      errors++; $display("FAIL stall_fire got req=%b kill=%b want 1 1", if_req, if_kill); end
    tick();
    checks++; if (PC_IF !== 32'h8000_1000) begin
      errors++; $display("FAIL stall_pc got %h want 80001000", PC_IF); end
  endtask

  task automatic test_codes();
    PCSel = 3'b111;
    #1;
    checks++; if (if_kill !== 1'b0) begin
      errors++; $display("FAIL pc4alias_kill got %b want 0", if_kill); end
    tick();
    checks++; if (PC_IF !== 32'h8000_1004) begin
      errors++; $display("FAIL pc4alias_pc got %h want 80001004", PC_IF); end
    PCSel = 3'b010; EPC = 32'h8000_0206;
    #1;
    checks++; if (if_kill !== 1'b1) begin
      errors++; $display("FAIL epc_kill got %b want 1", if_kill); end
    tick();
    PCSel = 3'b000;
    #1;
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (PC_IF !== 32'h8000_0206 || addr_err !== 1'b1 || if_req !== 1'b0) begin
      errors++; $display("FAIL epc_align got pc=%h err=%b req=%b want 80000206 1 0",
                         PC_IF, addr_err, if_req); end
`else
    checks++; if (PC_IF !== 32'h8000_0204 || addr_err !== 1'b0 || if_req !== 1'b1) begin
      errors++; $display("FAIL epc_align got pc=%h err=%b req=%b want 80000204 0 1",
                         PC_IF, addr_err, if_req); end
`endif
  endtask

  task automatic test_back_to_back();
    PCSel = 3'b001; JumpAddr = 32'hFFFF_FFFC;
    tick();
    PCSel = 3'b000;
    #1;
    checks++; if (PC_IF !== 32'hFFFF_FFFC || addr_err !== 1'b0) begin
      errors++; $display("FAIL jump_pc got pc=%h err=%b want fffffffc 0", PC_IF, addr_err); end
    tick();
    checks++; if (PC_IF !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_pc got %h want 00000000", PC_IF); end
    tick();
    checks++; if (PC_IF !== 32'h0000_0004) begin
      errors++; $display("FAIL after_wrap got %h want 00000004", PC_IF); end
  endtask

  task automatic test_reset_mid();
    if_ready = 1'b0;
    tick();
    checks++; if (if_req !== 1'b1) begin
      errors++; $display("FAIL mid_outstanding got %b want 1", if_req); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (PC_IF !== 32'hBFC0_0000 || if_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset got pc=%h req=%b want bfc00000 0", PC_IF, if_req); end
    checks++; if (if_kill !== 1'b0 || addr_err !== 1'b0) begin
      errors++; $display("FAIL mid_flags got kill=%b err=%b want 0 0", if_kill, addr_err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_branch_hold();
    test_latest_wins();
    test_stall();
    test_codes();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
